// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath width and word type for the MIPS register file and datapath
package mips_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/d_ff.sv
// rtl/d_ff.sv - 1-bit storage cell with async active-high load of a per-bit init value
module d_ff (
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic we,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  assign q_d = we ? d : q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= init;
    end else begin
      q_q <= q_d;
    end
  end

  // Bypass keeps q tracking init at level while reset is held, even if init moves between edges.
  assign q = reset ? init : q_q;

endmodule

// File: rtl/register_32bit.sv
// rtl/register_32bit.sv - 32-bit architectural register with decoder-qualified write and async preset
module register_32bit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] init_value,
  input  logic        regWrite,
  input  logic        decOut1b,
  input  logic [31:0] writeData,
  output logic [31:0] outBus
);

  logic  we;
  word_t init_w;
  word_t data_w;
  word_t q_w;

  assign we     = regWrite & decOut1b;
  assign init_w = init_value;
  assign data_w = writeData;

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    d_ff u_d_ff (
      .clk   (clk),
      .reset (reset),
      .init  (init_w[i]),
      .we    (we),
      .d     (data_w[i]),
      .q     (q_w[i])
    );
  end

  assign outBus = q_w;

endmodule

// File: tb/tb_register_32bit.sv
// tb/tb_register_32bit.sv - directed self-checking bench for register_32bit
module tb_register_32bit;

  logic        clk;
  logic        reset;
  logic [31:0] init_value;
  logic        regWrite;
  logic        decOut1b;
  logic [31:0] writeData;
  logic [31:0] outBus;

  int n_checks;
  int n_pass;

  register_32bit dut (
    .clk        (clk),
    .reset      (reset),
    .init_value (init_value),
    .regWrite   (regWrite),
    .decOut1b   (decOut1b),
    .writeData  (writeData),
    .outBus     (outBus)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: outBus=%0d (0x%08h) required %0d (0x%08h) at t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset      = 1'b1;
    init_value = 32'd212;
    writeData  = 32'd546;
    regWrite   = 1'b0;
    decOut1b   = 1'b0;

    #1;  // t=1, before first edge
    check_val("reset_load_no_edge", outBus, 32'd212);
    #3;  // t=4
    check_val("reset_load_held", outBus, 32'd212);
    #4;  // t=8
    reset    = 1'b0;
    regWrite = 1'b1;
    decOut1b = 1'b1;
    #1;  // t=9
    check_val("deassert_retains_init", outBus, 32'd212);
    #2;  // t=11, after edge 10
    check_val("qualified_write", outBus, 32'd546);
    #1;  // t=12
    regWrite  = 1'b0;
    writeData = 32'd111;
    #3;  // t=15
    check_val("strobe_off_hold", outBus, 32'd546);
    #1;  // t=16
    regWrite = 1'b1;
    decOut1b = 1'b0;
    #3;  // t=19
    check_val("decoder_off_hold", outBus, 32'd546);
    #1;  // t=20
    decOut1b = 1'b1;
    #1;  // t=21
    check_val("no_write_between_edges", outBus, 32'd546);
    #2;  // t=23
    check_val("select_on_write", outBus, 32'd111);
    #1;  // t=24, write still enabled
    writeData = 32'd777;
    reset     = 1'b1;
    #1;  // t=25
    check_val("async_reset_immediate", outBus, 32'd212);
    #2;  // t=27
    check_val("reset_beats_write", outBus, 32'd212);
    #1;  // t=28
    writeData = 32'd999;
    #3;  // t=31
    check_val("reset_held_data_changes", outBus, 32'd212);
    #1;  // t=32
    init_value = 32'd300;
    #1;  // t=33
    check_val("reset_follows_init", outBus, 32'd300);
    #3;  // t=36
    reset    = 1'b0;
    regWrite = 1'b0;
    #3;  // t=39
    check_val("retains_last_init", outBus, 32'd300);
    #1;  // t=40
    regWrite  = 1'b1;
    writeData = 32'hDEAD_BEEF;
    #3;  // t=43
    check_val("all_bits_write", outBus, 32'hDEAD_BEEF);
    #1;  // t=44
    writeData = 32'h1234_5678;
    init_value = 32'h5A5A_A5A5;
    #1;  // t=45
    reset = 1'b1;
    #2;  // t=47
    check_val("same_edge_reset_wins", outBus, 32'h5A5A_A5A5);
    #1;  // t=48
    reset = 1'b0;
    #3;  // t=51, edge 50 writes
    check_val("write_after_release", outBus, 32'h1234_5678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
